// File: rtl/iq_dsp_pkg.sv
// Shared widths, FSM encoding and rounding helpers for the I/Q decimation stages.
package iq_dsp_pkg;

    localparam int IN_W     = 22;
    localparam int OUT_W    = 16;
    localparam int MAX_LOG2 = 7;
    localparam int ACC_W    = IN_W + MAX_LOG2;
    localparam int SHIFT_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   SAT_HI  = (ACC_W+1)'(OUT_MAX);
    localparam logic signed [ACC_W:0]   SAT_LO  = (ACC_W+1)'(OUT_MIN);

    // Round half up, arithmetic shift right, then clamp to the OUT_W range.
    // One guard bit keeps the rounding bias from wrapping a near-full-scale sum.
    function automatic logic signed [OUT_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] sum,
        input logic [SHIFT_W-1:0]      shift
    );
        logic signed [ACC_W:0] biased;
        logic signed [ACC_W:0] r;
        biased = {sum[ACC_W-1], sum} + ((ACC_W+1)'(1) << (shift - SHIFT_W'(1)));
        r      = biased >>> shift;
        if (r > SAT_HI) begin
            return OUT_MAX;
        end else if (r < SAT_LO) begin
            return OUT_MIN;
        end
        return r[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/iq_decim_avg_if.sv
// Sample-in / result-out signal bundle of the I/Q block averager.
interface iq_decim_avg_if;
    import iq_dsp_pkg::*;

    logic                    in_valid;
    logic signed [IN_W-1:0]  i_in;
    logic signed [IN_W-1:0]  q_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] i_out;
    logic signed [OUT_W-1:0] q_out;

    modport master (
        output in_valid, i_in, q_in, out_ready,
        input  out_valid, i_out, q_out
    );

    modport slave (
        input  in_valid, i_in, q_in, out_ready,
        output out_valid, i_out, q_out
    );

endinterface

// File: rtl/iq_round_sat.sv
// Per-channel scaler: block sum -> rounded, saturated OUT_W sample.
module iq_round_sat
    import iq_dsp_pkg::*;
(
    input  logic signed [ACC_W-1:0]   sum,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [OUT_W-1:0]   res
);

    assign res = round_sat(sum, shift);

endmodule

// File: rtl/iq_decim_avg.sv
// Accumulate-and-dump averager over 2^k I/Q samples with a one-deep result register.
//
// state   | meaning
// ST_IDLE | stopped; partial sums cleared, pending result kept
// ST_RUN  | accumulating samples, dumping one result per 2^k samples
module iq_decim_avg
    import iq_dsp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [2:0]     decim_log2,
    iq_decim_avg_if.slave  bus,
    output logic           overflow,
    output logic           busy
);

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              k_lat;
    logic [MAX_LOG2-1:0]     count;
    logic [MAX_LOG2-1:0]     count_last;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic [SHIFT_W-1:0]      shift;
    logic signed [OUT_W-1:0] res_i;
    logic signed [OUT_W-1:0] res_q;
    logic                    take;
    logic                    dump;

    assign count_last = MAX_LOG2'(((MAX_LOG2+1)'(1) << k_lat) - (MAX_LOG2+1)'(1));
    assign take       = (state == ST_RUN) && en && bus.in_valid;
    assign dump       = take && (count == count_last);
    assign sum_i      = acc_i + {{MAX_LOG2{bus.i_in[IN_W-1]}}, bus.i_in};
    assign sum_q      = acc_q + {{MAX_LOG2{bus.q_in[IN_W-1]}}, bus.q_in};
    assign shift      = SHIFT_W'(k_lat) + SHIFT_W'(IN_W - OUT_W);
    assign busy       = (state == ST_RUN);

    iq_round_sat u_rs_i (.sum(sum_i), .shift(shift), .res(res_i));
    iq_round_sat u_rs_q (.sum(sum_q), .shift(shift), .res(res_q));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: en alone moves between idle and running.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en)  state_nxt = ST_RUN;
            ST_RUN:  if (!en) state_nxt = ST_IDLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Accumulators, sample counter and latched exponent; k only changes at block start.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_lat <= '0;
            count <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else if (state == ST_IDLE) begin
            if (en) begin
                k_lat <= decim_log2;
                count <= '0;
                acc_i <= '0;
                acc_q <= '0;
            end
        end else if (!en) begin
            count <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else if (dump) begin
            k_lat <= decim_log2;
            count <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else if (take) begin
            count <= count + MAX_LOG2'(1);
            acc_i <= sum_i;
            acc_q <= sum_q;
        end
    end

    // Output register: a dump loads only if the slot is free or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.i_out     <= '0;
            bus.q_out     <= '0;
            overflow      <= 1'b0;
        end else begin
            if (dump && (!bus.out_valid || bus.out_ready)) begin
                bus.out_valid <= 1'b1;
                bus.i_out     <= res_i;
                bus.q_out     <= res_q;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (dump && bus.out_valid && !bus.out_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iq_decim_avg.sv
// Directed bench for iq_decim_avg: expected results are queued at stimulus time
// and popped by a monitor on each output transfer.
module tb_iq_decim_avg;
    import iq_dsp_pkg::*;

    typedef struct {
        int i;
        int q;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] decim_log2;
    logic       overflow;
    logic       busy;

    iq_decim_avg_if bus();

    iq_decim_avg dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .decim_log2 (decim_log2),
        .bus        (bus),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input int q);
        exp_t e;
        e.i = i;
        e.q = q;
        sb.push_back(e);
    endtask

    task automatic samples(input int n, input int i, input int q);
        bus.in_valid = 1'b1;
        bus.i_in     = IN_W'(i);
        bus.q_in     = IN_W'(q);
        repeat (n) tick();
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid&&ready here.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got i=%0d q=%0d expected none",
                         $signed(bus.i_out), $signed(bus.q_out));
            end else begin
                mon_e = sb.pop_front();
                check("out_i", int'($signed(bus.i_out)), mon_e.i);
                check("out_q", int'($signed(bus.q_out)), mon_e.q);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        decim_log2    = 3'd0;
        bus.in_valid  = 1'b0;
        bus.i_in      = '0;
        bus.q_in      = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_i", int'($signed(bus.i_out)), 0);
        check("rst_q", int'($signed(bus.q_out)), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // k=2 constant input: one result every 4th cycle.
        decim_log2 = 3'd2;
        bus.in_valid = 1'b1;
        bus.i_in = IN_W'(100000);
        bus.q_in = IN_W'(-100000);
        repeat (3) push(1563, -1562);
        en = 1'b1;
        tick();
        check("a_busy", int'(busy), 1);
        for (int n = 1; n <= 12; n++) begin
            tick();
            check("a_valid", int'(bus.out_valid), int'(n % 4 == 0));
        end
        en = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("a_busy_off", int'(busy), 0);

        // k=0 passthrough: saturation at both rails and rounding of halves.
        decim_log2 = 3'd0;
        en = 1'b1;
        tick();
        push(32767, -32768);   samples(1, 2097151, -2097152);
        push(-32768, 32767);   samples(1, -2097152, 2097151);
        push(16, -16);         samples(1, 1000, -1000);
        push(1, 0);            samples(1, 32, -32);
        bus.in_valid = 1'b0;
        en = 1'b0;
        repeat (2) tick();

        // k=3 with a stalled sink: second result dropped, first held.
        bus.out_ready = 1'b0;
        decim_log2 = 3'd3;
        en = 1'b1;
        tick();
        push(13, -12);
        samples(8, 800, -800);
        check("c_valid", int'(bus.out_valid), 1);
        check("c_i1", int'($signed(bus.i_out)), 13);
        check("c_q1", int'($signed(bus.q_out)), -12);
        check("c_ovf0", int'(overflow), 0);
        samples(7, 1600, -1600);
        check("c_ovf_pre", int'(overflow), 0);
        samples(1, 1600, -1600);
        check("c_ovf1", int'(overflow), 1);
        check("c_i_held", int'($signed(bus.i_out)), 13);
        check("c_q_held", int'($signed(bus.q_out)), -12);
        samples(4, -2000, 2000);
        check("c_i_held2", int'($signed(bus.i_out)), 13);
        push(-31, 31);
        bus.out_ready = 1'b1;
        samples(4, -2000, 2000);
        check("c_valid3", int'(bus.out_valid), 1);
        en = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("c_ovf_sticky", int'(overflow), 1);

        // Gap test: valid every other cycle, dump on the 4th valid sample.
        decim_log2 = 3'd2;
        en = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        push(63, -62);
        bus.i_in = IN_W'(4000);
        bus.q_in = IN_W'(-4000);
        for (int c = 0; c <= 6; c++) begin
            bus.in_valid = (c % 2 == 0);
            tick();
            check("gap_valid", int'(bus.out_valid), int'(c == 6));
        end
        bus.in_valid = 1'b0;
        en = 1'b0;
        tick();

        // Exponent change mid-block takes effect at the next block.
        decim_log2 = 3'd2;
        en = 1'b1;
        tick();
        push(4, -4);
        samples(2, 256, -256);
        decim_log2 = 3'd4;
        samples(2, 256, -256);
        check("e_dump4", int'(bus.out_valid), 1);
        push(16, -16);
        samples(15, 1024, -1024);
        check("e_no_dump15", int'(bus.out_valid), 0);
        samples(1, 1024, -1024);
        check("e_dump16", int'(bus.out_valid), 1);

        // en low mid-block discards the partial sum.
        samples(3, 5000, 5000);
        check("e_busy", int'(busy), 1);
        en = 1'b0;
        tick();
        check("e_busy_off", int'(busy), 0);
        decim_log2 = 3'd2;
        en = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        push(4, -4);
        samples(4, 256, -256);
        check("e_restart", int'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        en = 1'b0;
        tick();

        // Reset with a pending result and a partial block.
        bus.out_ready = 1'b0;
        decim_log2 = 3'd2;
        en = 1'b1;
        tick();
        samples(6, 256, -256);
        check("f_pending", int'(bus.out_valid), 1);
        rst = 1'b1;
        tick();
        check("f_valid", int'(bus.out_valid), 0);
        check("f_ovf", int'(overflow), 0);
        check("f_i", int'($signed(bus.i_out)), 0);
        check("f_q", int'($signed(bus.q_out)), 0);
        check("f_busy", int'(busy), 0);
        rst = 1'b0;
        en = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        decim_log2 = 3'd0;
        en = 1'b1;
        tick();
        push(4, -4);
        samples(1, 256, -256);
        bus.in_valid = 1'b0;
        en = 1'b0;
        repeat (3) tick();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_decim_avg.md
Name: iq_decim_avg

Overview:
Downstream consumer of the CORDIC rotator's 22-bit I/Q outputs (xout/yout). Averages a runtime-selectable block of 2^k samples per channel (accumulate-and-dump), rounds and saturates to 16-bit I/Q, and presents each result on a valid/ready output. Sits between the CORDIC mixer and the baseband sample sink.

Parameters:
IN_W, 22, input sample width (signed, two's complement)
OUT_W, 16, output sample width (signed)
MAX_LOG2, 7, largest decimation exponent; decimation ratio is 2^k, k in 0..MAX_LOG2

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
en  in  1  run enable; low holds the block idle
decim_log2  in  3  decimation exponent k; sampled only at block start
in_valid  in  1  input sample strobe (tie high when fed from the CORDIC every cycle)
i_in  in  IN_W  signed I sample (CORDIC xout)
q_in  in  IN_W  signed Q sample (CORDIC yout)
out_valid  out  1  output holds an unconsumed result
out_ready  in  1  sink accepts the result
i_out  out  OUT_W  averaged, rounded, saturated I
q_out  out  OUT_W  averaged, rounded, saturated Q
overflow  out  1  sticky: a result was dropped because the output register was full
busy  out  1  high in RUN

Behaviour:
- Reset: state=IDLE, accumulators=0, count=0, out_valid=0, i_out=q_out=0, overflow=0, busy=0. Reset mid-block discards the partial sums and any pending output.
- FSM states:
  - IDLE -> RUN when en=1. On entry, k_lat<=decim_log2, count<=0, acc<=0.
  - RUN -> IDLE when en=0. Partial sums are discarded; a pending output is kept.
  - decim_log2 changes take effect only at the next IDLE->RUN entry or at a block boundary (dump cycle).
- Accumulate: in RUN with in_valid=1, acc_i+=sext(i_in), acc_q+=sext(q_in). Accumulator width is IN_W+MAX_LOG2 (29), so the sum never overflows. count increments.
- Dump: when an accepted sample makes count==2^k-1:
  - The full sum including that sample is scaled, and acc restarts from 0 (the next sample starts a new block). count<=0, k_lat<=decim_log2.
  - Scaling: shift s=k_lat+IN_W-OUT_W (6..13). r=(sum + 2^(s-1)) >>> s, i.e. round half up. r is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The result is registered into i_out/q_out with out_valid=1 on the clock after the last sample, so latency = 1 cycle from the last sample.
- Output handshake: a transfer occurs when out_valid&&out_ready; out_valid then clears unless a new dump lands in the same cycle. In that case the new result loads and out_valid stays 1.
- Full output: dump while out_valid=1 and out_ready=0 -> the new result is dropped, the old one is held, overflow<=1 (sticky, cleared by rst only). Accumulation continues unaffected.
- in_valid=0 cycles do not advance count.
- k=0 gives one sample per block: pure round/saturate passthrough, one result per accepted sample.

Decomposition:
- Shared package iq_dsp_pkg:
  - IN_W/OUT_W defaults
  - FSM state encoding (ST_IDLE, ST_RUN)
  - a function for round-half-up arithmetic shift with saturation, reused by other decimating stages
- One sub-module, iq_round_sat (combinational: sum, shift -> saturated OUT_W), instanced once per channel. The top level holds the FSM, counter, accumulators and output register.

Test Plan:
- k=2, in_valid=1, i_in=100000, q_in=-100000 constant, out_ready=1 -> out_valid pulses every 4th cycle with i_out=1563, q_out=-1562.
- k=0, i_in=2097151 (max 22-bit) -> i_out=32767 (saturated). i_in=-2097152 -> -32768.
- k=3, out_ready=0 for 20 cycles -> first result held stable, overflow=1 after the second dump. Raising out_ready delivers the first result, then the third block's result.
- Gap test: k=2, in_valid toggling 1,0,1,0... -> dump after the 4th valid sample, i.e. 7 cycles after the first.
- decim_log2 changed 2->4 mid-block -> current block still completes at 4 samples, next block uses 16 samples. en=0 mid-block -> busy=0, partial sum discarded, next run starts from count 0.
- rst asserted with out_valid=1 and a partial block -> next cycle out_valid=0, overflow=0, i_out=q_out=0, state IDLE.
